// File: rtl/sync_fifo_flags_pkg.sv
// fifo_pkg: shared widths and parameter legality check for sync_fifo_flags
//   AW/CW       : pointer and count widths for the default depth
//   params_ok() : true when depth is a power of two >= 2 and thresholds are in range
package fifo_pkg;
    localparam int DEF_FIFOD = 8;
    localparam int AW = $clog2(DEF_FIFOD);
    localparam int CW = AW + 1;
    function automatic bit params_ok(input int fifod, input int afull, input int aempty);
        return fifod >= 2 && (fifod & (fifod - 1)) == 0 &&
               afull >= 1 && afull <= fifod && aempty >= 0 && aempty < fifod;
    endfunction
endpackage

// File: rtl/sync_fifo_flags_ram.sv
// fifo_ram: simple dual-port storage, synchronous write, asynchronous read
//   clk   : write clock
//   we    : write enable
//   waddr : write address, wdata : write data
//   raddr : read address,  rdata : combinational read data
module fifo_ram #(
    parameter int DATAD = 8,
    parameter int FIFOD = 8
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(FIFOD)-1:0] waddr,
    input  logic [DATAD-1:0]         wdata,
    input  logic [$clog2(FIFOD)-1:0] raddr,
    output logic [DATAD-1:0]         rdata
);
    logic [DATAD-1:0] mem [FIFOD];
    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: single-clock FIFO with count, almost flags, error pulses and FWFT option
//   clk, rst        : clock, synchronous active-high reset
//   in, wr          : write data and request
//   rd, out         : read request and read data
//   full, empty     : count == FIFOD / count == 0
//   almost_full     : count >= AFULL
//   almost_empty    : count <= AEMPTY
//   count           : occupancy 0..FIFOD
//   overflow        : one-cycle pulse after a rejected write
//   underflow       : one-cycle pulse after a rejected read
module sync_fifo_flags
    import fifo_pkg::*;
#(
    parameter int DATAD  = 8,
    parameter int FIFOD  = 8,
    parameter int AFULL  = FIFOD - 2,
    parameter int AEMPTY = 2,
    parameter int FWFT   = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATAD-1:0]       in,
    input  logic                   wr,
    input  logic                   rd,
    output logic [DATAD-1:0]       out,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [$clog2(FIFOD):0] count,
    output logic                   overflow,
    output logic                   underflow
);
    localparam int PW = $clog2(FIFOD);
    localparam int NW = PW + 1;

    if (!params_ok(FIFOD, AFULL, AEMPTY)) begin : g_bad_params
        $error("sync_fifo_flags: illegal FIFOD/AFULL/AEMPTY combination");
    end

    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic [DATAD-1:0] rdata;
    logic             rd_ok, wr_ok;

    // A read on a full FIFO frees the slot the concurrent write uses.
    assign rd_ok = rd && !empty;
    assign wr_ok = wr && (!full || rd_ok);

    assign full         = count == NW'(FIFOD);
    assign empty        = count == '0;
    assign almost_full  = count >= NW'(AFULL);
    assign almost_empty = count <= NW'(AEMPTY);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            count     <= (wr_ok && !rd_ok) ? count + 1'b1 :
                         (rd_ok && !wr_ok) ? count - 1'b1 : count;
            overflow  <= wr && !wr_ok;
            underflow <= rd && !rd_ok;
        end
    end

    // Reset takes priority over a same-cycle write, so storage is not touched.
    fifo_ram #(.DATAD(DATAD), .FIFOD(FIFOD)) u_ram (
        .clk   (clk),
        .we    (wr_ok && !rst),
        .waddr (wr_ptr),
        .wdata (in),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    if (FWFT != 0) begin : g_fwft
        assign out = rdata;
    end else begin : g_std
        always_ff @(posedge clk)
            if (rst) out <= '0;
            else if (rd_ok) out <= rdata;
    end
endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb_sync_fifo_flags: directed table-driven check of standard mode plus FWFT and reset sequences
module tb_sync_fifo_flags;
    logic       clk = 0;
    logic       rst = 1;
    logic [7:0] din = 0, dout, fin = 0, fout;
    logic       wr = 0, rd = 0, fwr = 0, frd = 0;
    logic       full, empty, af, ae, ov, un;
    logic       ffull, fempty, faf, fae, fov, fun;
    logic [3:0] cnt, fcnt;
    int         total = 0, bad = 0;

    always #5 clk = ~clk;

    sync_fifo_flags #(.DATAD(8), .FIFOD(8), .FWFT(0)) dut (
        .clk(clk), .rst(rst), .in(din), .wr(wr), .rd(rd), .out(dout),
        .full(full), .empty(empty), .almost_full(af), .almost_empty(ae),
        .count(cnt), .overflow(ov), .underflow(un)
    );

    sync_fifo_flags #(.DATAD(8), .FIFOD(8), .FWFT(1)) dutf (
        .clk(clk), .rst(rst), .in(fin), .wr(fwr), .rd(frd), .out(fout),
        .full(ffull), .empty(fempty), .almost_full(faf), .almost_empty(fae),
        .count(fcnt), .overflow(fov), .underflow(fun)
    );

    typedef struct {
        logic       w, r;
        logic [7:0] d;
        logic [7:0] out;
        int         cnt;
        logic       ov, un;
    } vec_t;

    vec_t vq[$];

    function automatic void add(input logic w, r, input logic [7:0] d, input logic [7:0] o,
                                input int c, input logic o_v, u_n);
        vec_t v;
        v.w = w; v.r = r; v.d = d; v.out = o; v.cnt = c; v.ov = o_v; v.un = u_n;
        vq.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic w, r, input logic [7:0] d);
        wr = w; rd = r; din = d;
        @(posedge clk); #1;
    endtask

    task automatic fstep(input logic w, r, input logic [7:0] d);
        fwr = w; frd = r; fin = d;
        @(posedge clk); #1;
    endtask

    initial begin
        // fill A0..A7, then one rejected write
        for (int i = 0; i < 8; i++) add(1, 0, 8'hA0 + 8'(i), 8'h00, i + 1, 0, 0);
        add(1, 0, 8'hEE, 8'h00, 8, 1, 0);
        add(0, 0, 8'h00, 8'h00, 8, 0, 0);
        // drain, then one rejected read
        for (int i = 0; i < 8; i++) add(0, 1, 8'h00, 8'hA0 + 8'(i), 7 - i, 0, 0);
        add(0, 1, 8'h00, 8'hA7, 0, 0, 1);
        add(0, 0, 8'h00, 8'hA7, 0, 0, 0);
        // full with simultaneous read/write of 5A
        for (int i = 0; i < 8; i++) add(1, 0, 8'hB0 + 8'(i), 8'hA7, i + 1, 0, 0);
        add(1, 1, 8'h5A, 8'hB0, 8, 0, 0);
        for (int i = 1; i < 8; i++) add(0, 1, 8'h00, 8'hB0 + 8'(i), 8 - i, 0, 0);
        add(0, 1, 8'h00, 8'h5A, 0, 0, 0);
        // empty with simultaneous read/write of 3C
        add(1, 1, 8'h3C, 8'h5A, 1, 0, 1);
        add(0, 1, 8'h00, 8'h3C, 0, 0, 0);
        // wrap-around: 00..13 streamed with occupancy up to 3
        for (int i = 0; i < 3; i++) add(1, 0, 8'(i), 8'h3C, i + 1, 0, 0);
        for (int i = 0; i < 17; i++) add(1, 1, 8'(i + 3), 8'(i), 3, 0, 0);
        for (int i = 0; i < 3; i++) add(0, 1, 8'h00, 8'(17 + i), 2 - i, 0, 0);

        // reset then idle
        repeat (2) @(posedge clk);
        #1 rst = 0;
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 8'h00);
            if (i == 0 || i == 9) begin
                chk("idle empty", empty, 1);
                chk("idle almost_empty", ae, 1);
                chk("idle full", full, 0);
                chk("idle almost_full", af, 0);
                chk("idle count", cnt, 0);
                chk("idle out", dout, 8'h00);
            end
            chk("idle overflow", ov, 0);
            chk("idle underflow", un, 0);
        end

        foreach (vq[i]) begin
            step(vq[i].w, vq[i].r, vq[i].d);
            chk($sformatf("row%0d out", i), dout, vq[i].out);
            chk($sformatf("row%0d count", i), cnt, 32'(vq[i].cnt));
            chk($sformatf("row%0d full", i), full, 32'(vq[i].cnt == 8));
            chk($sformatf("row%0d empty", i), empty, 32'(vq[i].cnt == 0));
            chk($sformatf("row%0d almost_full", i), af, 32'(vq[i].cnt >= 6));
            chk($sformatf("row%0d almost_empty", i), ae, 32'(vq[i].cnt <= 2));
            chk($sformatf("row%0d overflow", i), ov, 32'(vq[i].ov));
            chk($sformatf("row%0d underflow", i), un, 32'(vq[i].un));
        end
        step(0, 0, 8'h00);

        // FWFT: head visible without a read
        fstep(1, 0, 8'h11);
        chk("fwft empty after write", fempty, 0);
        chk("fwft head 11", fout, 8'h11);
        fstep(0, 0, 8'h00);
        chk("fwft head held", fout, 8'h11);
        fstep(1, 0, 8'h22);
        chk("fwft count 2", fcnt, 2);
        chk("fwft head still 11", fout, 8'h11);
        fstep(0, 1, 8'h00);
        chk("fwft next head 22", fout, 8'h22);
        chk("fwft count 1", fcnt, 1);
        fstep(0, 1, 8'h00);
        chk("fwft drained", fempty, 1);
        chk("fwft no underflow", fun, 0);

        // reset mid-operation with a concurrent write
        for (int i = 0; i < 5; i++) step(1, 0, 8'hC0 + 8'(i));
        chk("pre-reset count", cnt, 5);
        rst = 1;
        step(1, 0, 8'h77);
        rst = 0;
        chk("reset count", cnt, 0);
        chk("reset empty", empty, 1);
        chk("reset out", dout, 8'h00);
        chk("reset overflow", ov, 0);
        step(0, 0, 8'h00);
        chk("post-reset count", cnt, 0);
        step(0, 1, 8'h00);
        chk("post-reset underflow", un, 1);
        chk("post-reset out", dout, 8'h00);
        step(1, 0, 8'h99);
        step(0, 1, 8'h00);
        chk("post-reset read", dout, 8'h99);
        chk("post-reset final count", cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sync_fifo_flags.md
# sync_fifo_flags

Single-clock, parametrised FIFO that succeeds the dual-clock FIFO for same-domain buffering between pipeline stages. It adds:
- an occupancy count;
- programmable almost-full and almost-empty thresholds;
- overflow and underflow error pulses;
- a selectable first-word-fall-through (FWFT) read mode.

It sits between a producer and a consumer that share one clock domain, so no pointer synchronisation is required.

## Interface
Parameters:
- DATAD, 8, data width in bits (≥1)
- FIFOD, 8, depth in entries; power of two, ≥2
- AFULL, FIFOD-2, almost_full threshold; 1 ≤ AFULL ≤ FIFOD
- AEMPTY, 2, almost_empty threshold; 0 ≤ AEMPTY < FIFOD
- FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- in  in  DATAD  write data
- wr  in  1  write request
- rd  in  1  read request
- out  out  DATAD  read data
- full  out  1  count == FIFOD
- empty  out  1  count == 0
- almost_full  out  1  count ≥ AFULL
- almost_empty  out  1  count ≤ AEMPTY
- count  out  $clog2(FIFOD)+1  current occupancy, 0..FIFOD
- overflow  out  1  one-cycle pulse: a write was rejected
- underflow  out  1  one-cycle pulse: a read was rejected

## Operation
- Storage: FIFOD×DATAD array; wr_ptr and rd_ptr are $clog2(FIFOD) bits wide and wrap naturally from FIFOD-1 to 0.
- Read accept: rd_ok = rd && !empty.
- Write accept: wr_ok = wr && (!full || rd_ok).
  - When full, a simultaneous read frees a slot, so both operations are accepted.
  - When empty, a simultaneous write is accepted and the read is rejected.
- count update: +1 on wr_ok only, -1 on rd_ok only, unchanged on both or neither.
- wr_ok writes `in` to mem[wr_ptr] and increments wr_ptr. rd_ok increments rd_ptr.
- Rejected operations leave pointers, count and memory untouched.
- overflow is registered as wr && !wr_ok. underflow is registered as rd && !rd_ok.
- Standard mode (FWFT=0):
  - on rd_ok, out is loaded with mem[rd_ptr] at that edge;
  - otherwise out holds its last value.
- FWFT mode (FWFT=1):
  - out = mem[rd_ptr] combinationally; this is the head entry whenever !empty;
  - rd_ok consumes the head, and the next entry appears after the edge;
  - out is don't-care while empty.
- Flags full, empty, almost_full and almost_empty are combinational decodes of the registered count. They are glitch-free and never depend on wr or rd.

## Timing
- Reset (rst=1 at an edge):
  - pointers = 0, count = 0;
  - empty = 1, almost_empty = 1;
  - full = 0; almost_full = 0;
  - overflow = 0, underflow = 0;
  - out = 0 in standard mode.
  - Memory contents are not cleared.
- Reset overrides wr and rd in the same cycle. Reset during operation discards all stored data in one cycle.
- Write-to-flag latency: 1 cycle. After a wr_ok at edge N, count and empty change at edge N.
- Read latency:
  - standard mode: data appears on out 1 cycle after the rd edge;
  - FWFT mode: 0 cycles, because the head is visible as soon as empty=0 (one edge after the first write).
- Back-to-back wr or rd every cycle are supported at full throughput.
- overflow and underflow are high for exactly one cycle following each rejected request.

## Structure
- Package fifo_pkg:
  - localparams AW = $clog2(FIFOD) and CW = AW+1;
  - function that checks parameter legality (FIFOD power of two, AFULL and AEMPTY in range), used by an elaboration-time assertion.
- Sub-module fifo_ram:
  - simple dual-port storage with synchronous write and asynchronous read;
  - parameters DATAD and FIFOD.
- The top level holds the pointers, count, flag decode, error pulses and the read-mode generate branch.

## Test plan
- Reset then idle: after rst, expect empty=1, almost_empty=1, full=0, count=0, out=00, and no error pulses for 10 cycles.
- Fill and drain, FIFOD=8, standard mode:
  - write A0..A7 on consecutive cycles; almost_full rises at count=6 and full at count=8;
  - a 9th write gives overflow=1 for one cycle and count stays 8;
  - read 8 times; out = A0..A7, each one cycle after its rd;
  - a 9th read gives underflow=1 and count stays 0.
- Simultaneous events:
  - at full, wr=rd=1 with in=5A: count stays 8, no overflow, and 5A is returned last;
  - at empty, wr=rd=1 with in=3C: count becomes 1, underflow pulses, and the next read returns 3C.
- Wrap-around: 20 interleaved write/read pairs of data 00..13 with occupancy 0..3; out sequence is 00..13 in order with no flag errors.
- FWFT=1:
  - write 11; one cycle later empty=0 and out=11 with no rd;
  - write 22, then rd; out=22 on the next cycle.
- Reset mid-operation: at count=5, assert rst together with wr=1; next cycle count=0, empty=1, and the write is discarded.
